// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the CPU (port 0)
// and a host/loader (port 1). One access per cycle: grant in N, memory
// command in N+1, read data returned to the owning port in N+2.
module dmem_arbiter #(
   parameter int AW = 16,
   parameter int DW = 16,
   parameter int RR = 1
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          StatClr,
   // port 0: CPU load/store path
   input  logic          Req0,
   input  logic          We0,
   input  logic          Byte0,
   input  logic [AW-1:0] Addr0,
   input  logic [DW-1:0] WData0,
   output logic          Gnt0,
   output logic          RValid0,
   output logic [DW-1:0] RData0,
   output logic          Stall0,
   // port 1: host/loader path
   input  logic          Req1,
   input  logic          We1,
   input  logic          Byte1,
   input  logic [AW-1:0] Addr1,
   input  logic [DW-1:0] WData1,
   output logic          Gnt1,
   output logic          RValid1,
   output logic [DW-1:0] RData1,
   // memory side
   output logic          MemRead,
   output logic          MemWrite,
   output logic          MemByte,
   output logic [AW-1:0] MemAddr,
   output logic [DW-1:0] MemWData,
   input  logic [DW-1:0] MemRData,
   // statistics
   output logic [15:0]   StallCt
);

   localparam bit RR_EN = (RR != 0);

   logic          gnt0, gnt1;
   logic          lastgnt_q;    // 1 = port 1 won the most recent grant
   logic          memread_q, memwrite_q, membyte_q;
   logic [AW-1:0] memaddr_q;
   logic [DW-1:0] memwdata_q;
   logic          owner_q;      // port owning the access in the command stage
   logic          rvalid0_q, rvalid1_q;
   logic [DW-1:0] rdata0_q, rdata1_q;
   logic [15:0]   stallct_q, stallct_d;
   logic          sel_we, sel_byte;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   // Grant: a lone requester always wins; on a tie round-robin picks the port
   // that did not win last time, fixed priority always picks the CPU.
   always_comb begin
      gnt0 = Req0 & (~Req1 | ~RR_EN | lastgnt_q);
      gnt1 = Req1 & ~gnt0;
   end

   assign Gnt0   = gnt0;
   assign Gnt1   = gnt1;
   assign Stall0 = Req0 & ~gnt0;

   // Field mux for the winning port.
   always_comb begin
      sel_we    = gnt1 ? We1    : We0;
      sel_byte  = gnt1 ? Byte1  : Byte0;
      sel_addr  = gnt1 ? Addr1  : Addr0;
      sel_wdata = gnt1 ? WData1 : WData0;
   end

   // Round-robin history, only moves when a grant actually happens.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         lastgnt_q <= 1'b1;
      else if (gnt0 | gnt1)
         lastgnt_q <= gnt1;
   end

   // Command stage: register the granted access; strobes drop on idle cycles
   // while address/data keep their last values.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         membyte_q  <= 1'b0;
         memaddr_q  <= '0;
         memwdata_q <= '0;
         owner_q    <= 1'b0;
      end else if (gnt0 | gnt1) begin
         memread_q  <= ~sel_we;
         memwrite_q <= sel_we;
         membyte_q  <= sel_byte;
         memaddr_q  <= sel_addr;
         memwdata_q <= sel_wdata;
         owner_q    <= gnt1;
      end else begin
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
      end
   end

   assign MemRead  = memread_q;
   assign MemWrite = memwrite_q;
   assign MemByte  = membyte_q;
   assign MemAddr  = memaddr_q;
   assign MemWData = memwdata_q;

   // Return stage: capture memory data into the owning port for one cycle.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         rvalid0_q <= memread_q & ~owner_q;
         rvalid1_q <= memread_q &  owner_q;
         if (memread_q & ~owner_q) rdata0_q <= MemRData;
         if (memread_q &  owner_q) rdata1_q <= MemRData;
      end
   end

   assign RValid0 = rvalid0_q;
   assign RValid1 = rvalid1_q;
   assign RData0  = rdata0_q;
   assign RData1  = rdata1_q;

   // Stall counter next state: clear wins, otherwise saturating increment.
   always_comb begin
      stallct_d = stallct_q;
      if (StatClr)
         stallct_d = 16'h0000;
      else if (Stall0 && (stallct_q != 16'hFFFF))
         stallct_d = stallct_q + 16'd1;
   end

   // Stall counter register.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         stallct_q <= 16'h0000;
      else
         stallct_q <= stallct_d;
   end

   assign StallCt = stallct_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance share
// stimulus; each has its own behavioural memory.
module tb_dmem_arbiter;

   logic        Clk = 1'b0;
   logic        Reset, StatClr;
   logic        Req0, We0, Byte0, Req1, We1, Byte1;
   logic [15:0] Addr0, WData0, Addr1, WData1;

   logic        a_gnt0, a_rvalid0, a_stall0, a_gnt1, a_rvalid1;
   logic [15:0] a_rdata0, a_rdata1, a_memaddr, a_memwdata, a_memrdata, a_stallct;
   logic        a_memread, a_memwrite, a_membyte;
   logic        b_gnt0, b_rvalid0, b_stall0, b_gnt1, b_rvalid1;
   logic [15:0] b_rdata0, b_rdata1, b_memaddr, b_memwdata, b_memrdata, b_stallct;
   logic        b_memread, b_memwrite, b_membyte;

   logic [15:0] mem_a [256];
   logic [15:0] mem_b [256];
   logic        pre_we;
   logic [7:0]  pre_addr;
   logic [15:0] pre_data;

   int vectors, miscompares;

   typedef struct { int due; int port; logic [15:0] data; } ret_t;

   always #5 Clk = ~Clk;

   dmem_arbiter #(.AW(16), .DW(16), .RR(1)) u_rr (
      .Clk(Clk), .Reset(Reset), .StatClr(StatClr),
      .Req0(Req0), .We0(We0), .Byte0(Byte0), .Addr0(Addr0), .WData0(WData0),
      .Gnt0(a_gnt0), .RValid0(a_rvalid0), .RData0(a_rdata0), .Stall0(a_stall0),
      .Req1(Req1), .We1(We1), .Byte1(Byte1), .Addr1(Addr1), .WData1(WData1),
      .Gnt1(a_gnt1), .RValid1(a_rvalid1), .RData1(a_rdata1),
      .MemRead(a_memread), .MemWrite(a_memwrite), .MemByte(a_membyte),
      .MemAddr(a_memaddr), .MemWData(a_memwdata), .MemRData(a_memrdata),
      .StallCt(a_stallct));

   dmem_arbiter #(.AW(16), .DW(16), .RR(0)) u_fp (
      .Clk(Clk), .Reset(Reset), .StatClr(StatClr),
      .Req0(Req0), .We0(We0), .Byte0(Byte0), .Addr0(Addr0), .WData0(WData0),
      .Gnt0(b_gnt0), .RValid0(b_rvalid0), .RData0(b_rdata0), .Stall0(b_stall0),
      .Req1(Req1), .We1(We1), .Byte1(Byte1), .Addr1(Addr1), .WData1(WData1),
      .Gnt1(b_gnt1), .RValid1(b_rvalid1), .RData1(b_rdata1),
      .MemRead(b_memread), .MemWrite(b_memwrite), .MemByte(b_membyte),
      .MemAddr(b_memaddr), .MemWData(b_memwdata), .MemRData(b_memrdata),
      .StallCt(b_stallct));

   // Behavioural memories: combinational read, write at the clock edge.
   assign a_memrdata = mem_a[a_memaddr[7:0]];
   assign b_memrdata = mem_b[b_memaddr[7:0]];

   always @(posedge Clk) begin
      if (pre_we) begin
         mem_a[pre_addr] <= pre_data;
         mem_b[pre_addr] <= pre_data;
      end else begin
         if (a_memwrite) begin
            if (a_membyte) mem_a[a_memaddr[7:0]][7:0] <= a_memwdata[7:0];
            else           mem_a[a_memaddr[7:0]]      <= a_memwdata;
         end
         if (b_memwrite) begin
            if (b_membyte) mem_b[b_memaddr[7:0]][7:0] <= b_memwdata[7:0];
            else           mem_b[b_memaddr[7:0]]      <= b_memwdata;
         end
      end
   end

   task automatic next_cyc();
      @(posedge Clk); #1;
   endtask

   task automatic idle();
      Req0 = 0; We0 = 0; Byte0 = 0; Addr0 = 0; WData0 = 0;
      Req1 = 0; We1 = 0; Byte1 = 0; Addr1 = 0; WData1 = 0;
      StatClr = 0;
   endtask

   task automatic do_reset();
      idle();
      Reset = 0;
      @(negedge Clk);
      next_cyc();
      Reset = 1;
   endtask

   task automatic preload(input logic [7:0] addr, input logic [15:0] data);
      pre_we = 1; pre_addr = addr; pre_data = data;
      next_cyc();
      pre_we = 0;
   endtask

   task automatic test_reset();
      idle();
      Reset = 0;
      @(negedge Clk);
      vectors++; if ({a_memread, a_memwrite, a_membyte, a_rvalid0, a_rvalid1} !== 5'b0) begin miscompares++; $display("FAIL reset_a_strobes got=%b exp=00000", {a_memread, a_memwrite, a_membyte, a_rvalid0, a_rvalid1}); end
      vectors++; if ({a_memaddr, a_memwdata, a_rdata0, a_rdata1, a_stallct} !== 80'h0) begin miscompares++; $display("FAIL reset_a_regs got=%h exp=0", {a_memaddr, a_memwdata, a_rdata0, a_rdata1, a_stallct}); end
      vectors++; if ({b_memread, b_memwrite, b_membyte, b_rvalid0, b_rvalid1} !== 5'b0) begin miscompares++; $display("FAIL reset_b_strobes got=%b exp=00000", {b_memread, b_memwrite, b_membyte, b_rvalid0, b_rvalid1}); end
      vectors++; if ({b_memaddr, b_memwdata, b_rdata0, b_rdata1, b_stallct} !== 80'h0) begin miscompares++; $display("FAIL reset_b_regs got=%h exp=0", {b_memaddr, b_memwdata, b_rdata0, b_rdata1, b_stallct}); end
      vectors++; if ({a_gnt0, a_gnt1, a_stall0, b_gnt0, b_gnt1, b_stall0} !== 6'b0) begin miscompares++; $display("FAIL reset_idle_gnt got=%b exp=000000", {a_gnt0, a_gnt1, a_stall0, b_gnt0, b_gnt1, b_stall0}); end
      next_cyc();
      Reset = 1;
      // reset asserted in the middle of a read: grant in cycle 3, reset in cycle 4
      next_cyc();
      next_cyc();
      Req0 = 1; We0 = 0; Addr0 = 16'h0050;
      @(negedge Clk);
      vectors++; if ({a_gnt0, b_gnt0} !== 2'b11) begin miscompares++; $display("FAIL rstmid_gnt got=%b exp=11", {a_gnt0, b_gnt0}); end
      next_cyc();
      Req0 = 0;
      vectors++; if ({a_memread, b_memread} !== 2'b11) begin miscompares++; $display("FAIL rstmid_memread got=%b exp=11", {a_memread, b_memread}); end
      #2 Reset = 0;
      #1;
      vectors++; if ({a_memread, a_memwrite, b_memread, b_memwrite} !== 4'b0) begin miscompares++; $display("FAIL rstmid_strobes got=%b exp=0000", {a_memread, a_memwrite, b_memread, b_memwrite}); end
      next_cyc();
      Reset = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge Clk);
         vectors++; if ({a_rvalid0, b_rvalid0} !== 2'b00) begin miscompares++; $display("FAIL rstmid_no_rvalid cyc=%0d got=%b exp=00", k, {a_rvalid0, b_rvalid0}); end
         next_cyc();
      end
      vectors++; if (a_stallct !== 16'h0) begin miscompares++; $display("FAIL rstmid_stallct got=%h exp=0000", a_stallct); end
   endtask

   task automatic test_single_read();
      preload(8'h10, 16'hBEEF);
      Req0 = 1; We0 = 0; Byte0 = 0; Addr0 = 16'h0010;
      @(negedge Clk);
      vectors++; if ({a_gnt0, a_gnt1, a_stall0} !== 3'b100) begin miscompares++; $display("FAIL single_gnt got=%b exp=100", {a_gnt0, a_gnt1, a_stall0}); end
      next_cyc();
      Req0 = 0;
      @(negedge Clk);
      vectors++; if ({a_memread, a_memwrite, a_memaddr} !== {2'b10, 16'h0010}) begin miscompares++; $display("FAIL single_cmd got=%b%b/%h exp=10/0010", a_memread, a_memwrite, a_memaddr); end
      vectors++; if (a_rvalid0 !== 1'b0) begin miscompares++; $display("FAIL single_rvalid_early got=%b exp=0", a_rvalid0); end
      next_cyc();
      @(negedge Clk);
      vectors++; if ({a_rvalid0, a_rvalid1, a_rdata0} !== {2'b10, 16'hBEEF}) begin miscompares++; $display("FAIL single_ret got=%b%b/%h exp=10/beef", a_rvalid0, a_rvalid1, a_rdata0); end
      vectors++; if (a_memread !== 1'b0) begin miscompares++; $display("FAIL single_memread_drop got=%b exp=0", a_memread); end
      next_cyc();
      @(negedge Clk);
      vectors++; if ({a_rvalid0, a_rdata0} !== {1'b0, 16'hBEEF}) begin miscompares++; $display("FAIL single_hold got=%b/%h exp=0/beef", a_rvalid0, a_rdata0); end
      next_cyc();
   endtask

   task automatic test_contention();
      do_reset();
      Req0 = 1; We0 = 0; Addr0 = 16'h0003;
      Req1 = 1; We1 = 0; Addr1 = 16'h0004;
      for (int k = 0; k < 4; k++) begin
         @(negedge Clk);
         vectors++; if ({a_gnt0, a_gnt1, a_stall0} !== {k % 2 == 0, k % 2 == 1, k % 2 == 1}) begin miscompares++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", k + 1, {a_gnt0, a_gnt1, a_stall0}, {k % 2 == 0, k % 2 == 1, k % 2 == 1}); end
         vectors++; if ({b_gnt0, b_gnt1, b_stall0} !== 3'b100) begin miscompares++; $display("FAIL fp_gnt cyc=%0d got=%b exp=100", k + 1, {b_gnt0, b_gnt1, b_stall0}); end
         next_cyc();
      end
      Req0 = 0;
      @(negedge Clk);
      vectors++; if ({b_gnt0, b_gnt1} !== 2'b01) begin miscompares++; $display("FAIL fp_gnt1_cyc5 got=%b exp=01", {b_gnt0, b_gnt1}); end
      vectors++; if (a_stallct !== 16'd2) begin miscompares++; $display("FAIL rr_stallct got=%0d exp=2", a_stallct); end
      vectors++; if (b_stallct !== 16'd0) begin miscompares++; $display("FAIL fp_stallct got=%0d exp=0", b_stallct); end
      next_cyc();
      idle();
      repeat (3) next_cyc();
   endtask

   task automatic test_write_then_read();
      logic seen_rv1;
      seen_rv1 = 0;
      Req1 = 1; We1 = 1; Byte1 = 0; Addr1 = 16'h0020; WData1 = 16'h1234;
      @(negedge Clk);
      vectors++; if ({a_gnt0, a_gnt1} !== 2'b01) begin miscompares++; $display("FAIL wr_gnt1 got=%b exp=01", {a_gnt0, a_gnt1}); end
      next_cyc();
      idle();
      Req0 = 1; We0 = 0; Byte0 = 1; Addr0 = 16'h0020;
      @(negedge Clk);
      vectors++; if ({a_gnt0, a_memwrite, a_memread, a_membyte, a_memaddr, a_memwdata} !== {4'b1100, 16'h0020, 16'h1234}) begin miscompares++; $display("FAIL wr_cmd got=%b%b%b%b/%h/%h exp=1100/0020/1234", a_gnt0, a_memwrite, a_memread, a_membyte, a_memaddr, a_memwdata); end
      seen_rv1 |= a_rvalid1;
      next_cyc();
      idle();
      @(negedge Clk);
      vectors++; if ({a_memread, a_memwrite, a_membyte} !== 3'b101) begin miscompares++; $display("FAIL rd_cmd got=%b exp=101", {a_memread, a_memwrite, a_membyte}); end
      seen_rv1 |= a_rvalid1;
      next_cyc();
      @(negedge Clk);
      vectors++; if ({a_rvalid0, a_rdata0} !== {1'b1, 16'h1234}) begin miscompares++; $display("FAIL rd_after_wr got=%b/%h exp=1/1234", a_rvalid0, a_rdata0); end
      seen_rv1 |= a_rvalid1;
      vectors++; if (seen_rv1 !== 1'b0) begin miscompares++; $display("FAIL wr_no_rvalid1 got=%b exp=0", seen_rv1); end
      next_cyc();
   endtask

   task automatic test_random();
      logic        act [2];
      logic        we [2];
      logic        by [2];
      logic [15:0] ad [2];
      logic [15:0] wd [2];
      logic [15:0] shadow [16];
      logic [15:0] exp_rd [2];
      logic [15:0] cnt;
      logic        v [2];
      logic        clr, stall;
      ret_t        q [$];
      ret_t        r;
      int          last, g;
      for (int i = 0; i < 16; i++) begin
         shadow[i] = 16'($urandom);
         preload(8'(i), shadow[i]);
      end
      do_reset();
      last = 1; cnt = 0;
      for (int p = 0; p < 2; p++) begin act[p] = 0; exp_rd[p] = 0; end
      for (int c = 0; c < 404; c++) begin
         for (int p = 0; p < 2; p++)
            if (!act[p] && c < 400 && $urandom_range(0, 9) < 6) begin
               act[p] = 1; we[p] = 1'($urandom); by[p] = 1'($urandom);
               ad[p] = 16'($urandom_range(0, 15)); wd[p] = 16'($urandom);
            end
         clr = ($urandom_range(0, 19) == 0);
         Req0 = act[0]; We0 = we[0]; Byte0 = by[0]; Addr0 = ad[0]; WData0 = wd[0];
         Req1 = act[1]; We1 = we[1]; Byte1 = by[1]; Addr1 = ad[1]; WData1 = wd[1];
         StatClr = clr;
         if (act[0] && act[1]) g = (last == 1) ? 0 : 1;
         else if (act[0])      g = 0;
         else if (act[1])      g = 1;
         else                  g = -1;
         stall = act[0] && (g != 0);
         v[0] = 0; v[1] = 0;
         while (q.size() > 0 && q[0].due == c) begin
            r = q.pop_front();
            v[r.port] = 1; exp_rd[r.port] = r.data;
         end
         @(negedge Clk);
         vectors++; if ({a_gnt0, a_gnt1, a_stall0} !== {g == 0, g == 1, stall}) begin miscompares++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", c, {a_gnt0, a_gnt1, a_stall0}, {g == 0, g == 1, stall}); end
         vectors++; if (a_stallct !== cnt) begin miscompares++; $display("FAIL rand_stallct cyc=%0d got=%0d exp=%0d", c, a_stallct, cnt); end
         vectors++; if ({a_rvalid0, a_rdata0} !== {v[0], exp_rd[0]}) begin miscompares++; $display("FAIL rand_ret0 cyc=%0d got=%b/%h exp=%b/%h", c, a_rvalid0, a_rdata0, v[0], exp_rd[0]); end
         vectors++; if ({a_rvalid1, a_rdata1} !== {v[1], exp_rd[1]}) begin miscompares++; $display("FAIL rand_ret1 cyc=%0d got=%b/%h exp=%b/%h", c, a_rvalid1, a_rdata1, v[1], exp_rd[1]); end
         if (g >= 0) begin
            if (we[g]) begin
               if (by[g]) shadow[ad[g][3:0]][7:0] = wd[g][7:0];
               else       shadow[ad[g][3:0]]      = wd[g];
            end else begin
               q.push_back('{due: c + 2, port: g, data: shadow[ad[g][3:0]]});
            end
            last = g;
            act[g] = 0;
         end
         if (clr)                          cnt = 16'h0;
         else if (stall && cnt != 16'hFFFF) cnt = cnt + 16'd1;
         next_cyc();
      end
      idle();
      next_cyc();
   endtask

   task automatic test_saturation();
      logic [15:0] exp;
      do_reset();
      force u_rr.lastgnt_q = 1'b0;
      Req0 = 1; We0 = 0; Addr0 = 16'h0041;
      Req1 = 1; We1 = 1; Addr1 = 16'h0040; WData1 = 16'h5A5A;
      for (int i = 0; i <= 70000; i++) begin
         if (i == 1000 || i == 65534 || i == 65535 || i == 65536 || i == 70000) begin
            @(negedge Clk);
            exp = (i > 65535) ? 16'hFFFF : i[15:0];
            vectors++; if (a_stallct !== exp) begin miscompares++; $display("FAIL sat_stallct at=%0d got=%h exp=%h", i, a_stallct, exp); end
            vectors++; if ({a_gnt1, a_stall0} !== 2'b11) begin miscompares++; $display("FAIL sat_forced_stall at=%0d got=%b exp=11", i, {a_gnt1, a_stall0}); end
         end
         next_cyc();
      end
      StatClr = 1;
      next_cyc();
      StatClr = 0;
      @(negedge Clk);
      vectors++; if (a_stallct !== 16'h0) begin miscompares++; $display("FAIL sat_clr got=%h exp=0000", a_stallct); end
      next_cyc();
      @(negedge Clk);
      vectors++; if (a_stallct !== 16'h1) begin miscompares++; $display("FAIL sat_resume got=%h exp=0001", a_stallct); end
      release u_rr.lastgnt_q;
      idle();
      next_cyc();
      do_reset();
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      pre_we = 0; pre_addr = 0; pre_data = 0;
      Reset = 0;
      idle();
      next_cyc();
      test_reset();
      test_single_read();
      test_contention();
      test_write_then_read();
      test_random();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
